pull_slice_arbiter: RTL and testbench

- Clocked arbiter that shares one 18-bit pull-style source channel between N_REQ requester channels.
- Each requester sees a 16-bit field sliced from the source word at its own fixed bit offset.
- Source and requester channels use four-phase return-to-zero handshakes (r/a/d).
- All channel inputs are synchronous to clk; any synchronisers sit outside this block.

---
 rtl/pull_slice_pkg.sv | 22 ++
 rtl/pull_slice_arbiter_rr_pick.sv | 26 ++
 rtl/pull_slice_arbiter.sv | 159 +++++++++++++++
 tb/tb_pull_slice_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pull_slice_pkg.sv
// Shared types and helpers for the pull-style slice arbiter.
package pull_slice_pkg;

  localparam int unsigned LSB_BITS = 8;
  localparam int unsigned MAX_REQ  = 8;

  typedef enum logic [2:0] {
    IDLE,
    SRC_REQ,
    SRC_RTZ,
    ACK,
    ABORT,
    IDLE_WAIT
  } state_e;

  // Field LSB of requester idx from a packed 8-bit-per-entry vector.
  function automatic logic [LSB_BITS-1:0] lsb_of(input logic [LSB_BITS*MAX_REQ-1:0] vec,
                                                 input int unsigned idx);
    return vec[idx*LSB_BITS +: LSB_BITS];
  endfunction

endpackage

// File: rtl/pull_slice_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit at or after ptr, wrapping modulo N.
module rr_pick #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          any
);

  int j;

  // Descending scan so the smallest offset from ptr is assigned last and wins.
  always_comb begin
    idx = '0;
    any = |req;
    j   = 0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= int'(N)) j = j - int'(N);
      if (req[IW'(j)]) idx = IW'(j);
    end
  end

endmodule

// File: rtl/pull_slice_arbiter.sv
// Shares one pull-style four-phase source between N_REQ requesters, each
// receiving its own fixed-offset field of the source word.
module pull_slice_arbiter
  import pull_slice_pkg::*;
#(
  parameter int unsigned          N_REQ   = 2,
  parameter int unsigned          SRC_W   = 18,
  parameter int unsigned          FLD_W   = 16,
  parameter logic [8*N_REQ-1:0]   LSB_VEC = {8'd2, 8'd1},
  parameter int unsigned          TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_r,
  output logic [N_REQ-1:0]           req_a,
  output logic [FLD_W-1:0]           req_d,
  output logic                       src_r,
  input  logic                       src_a,
  input  logic [SRC_W-1:0]           src_d,
  output logic [$clog2(N_REQ)-1:0]   grant,
  output logic                       busy,
  output logic                       err
);

  localparam int unsigned GW = $clog2(N_REQ);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  for (genvar g = 0; g < N_REQ; g++) begin : g_lsb_check
    if (32'(lsb_of(64'(LSB_VEC), g)) + FLD_W > SRC_W) begin : g_bad
      $error("pull_slice_arbiter: field of requester %0d exceeds SRC_W", g);
    end
  end

  state_e            state, state_n;
  logic [GW-1:0]     rr_ptr, rr_ptr_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [N_REQ-1:0]  req_a_n;
  logic [FLD_W-1:0]  req_d_n;
  logic              src_r_n;
  logic [GW-1:0]     grant_n;
  logic              busy_n;
  logic              err_n;

  logic [GW-1:0]     pick_idx;
  logic              pick_any;
  logic [FLD_W-1:0]  slice;
  logic [GW-1:0]     next_ptr;
  logic              timed_out;

  rr_pick #(.N(N_REQ), .IW(GW)) u_pick (
    .req (req_r),
    .ptr (rr_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Field of the currently granted requester, taken from the live source word.
  always_comb begin
    slice = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant == GW'(i)) slice = FLD_W'(src_d >> lsb_of(64'(LSB_VEC), i));
    end
  end

  assign next_ptr  = (grant == GW'(N_REQ - 1)) ? '0 : grant + GW'(1);
  assign timed_out = (cnt == CW'(TIMEOUT));

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_n  = state;
    rr_ptr_n = rr_ptr;
    cnt_n    = cnt;
    req_a_n  = req_a;
    req_d_n  = req_d;
    src_r_n  = src_r;
    grant_n  = grant;
    err_n    = 1'b0;

    unique case (state)
      IDLE: begin
        // A source still acknowledging a previous cycle blocks new requests.
        if (!src_a && pick_any) begin
          grant_n = pick_idx;
          src_r_n = 1'b1;
          cnt_n   = '0;
          state_n = SRC_REQ;
        end
      end
      SRC_REQ: begin
        if (src_a) begin
          req_d_n = slice;
          src_r_n = 1'b0;
          cnt_n   = '0;
          state_n = SRC_RTZ;
        end else if (timed_out) begin
          src_r_n = 1'b0;
          err_n   = 1'b1;
          state_n = ABORT;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      SRC_RTZ: begin
        if (!src_a) begin
          req_a_n        = '0;
          req_a_n[grant] = 1'b1;
          state_n        = ACK;
        end else if (timed_out) begin
          err_n   = 1'b1;
          state_n = ABORT;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ACK: begin
        if (!req_r[grant]) begin
          req_a_n  = '0;
          rr_ptr_n = next_ptr;
          state_n  = IDLE;
        end
      end
      ABORT: begin
        rr_ptr_n = next_ptr;
        state_n  = IDLE_WAIT;
      end
      IDLE_WAIT: begin
        if (!src_a) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      cnt    <= '0;
      req_a  <= '0;
      req_d  <= '0;
      src_r  <= 1'b0;
      grant  <= '0;
      busy   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      rr_ptr <= rr_ptr_n;
      cnt    <= cnt_n;
      req_a  <= req_a_n;
      req_d  <= req_d_n;
      src_r  <= src_r_n;
      grant  <= grant_n;
      busy   <= busy_n;
      err    <= err_n;
    end
  end

endmodule

// File: tb/tb_pull_slice_arbiter.sv
// Self-checking bench for pull_slice_arbiter (N_REQ=2, default LSBs, TIMEOUT=255).
module tb_pull_slice_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_r;
  logic [1:0]  req_a;
  logic [15:0] req_d;
  logic        src_r;
  logic        src_a;
  logic [17:0] src_d;
  logic        grant;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pull_slice_arbiter dut (
    .clk   (clk),
    .rst   (rst),
    .req_r (req_r),
    .req_a (req_a),
    .req_d (req_d),
    .src_r (src_r),
    .src_a (src_a),
    .src_d (src_d),
    .grant (grant),
    .busy  (busy),
    .err   (err)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  req_r;
    logic        src_a;
    logic [17:0] src_d;
    logic [1:0]  req_a;
    logic [15:0] req_d;
    logic        src_r;
    logic        grant;
    logic        busy;
    logic        err;
  } vec_t;

  vec_t tbl [14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    req_r = 2'b00;
    src_a = 1'b0;
    src_d = '0;
    step();
    rst = 1'b0;
  endtask

  // Completes one transaction for requester idx whose req_r is already high.
  task automatic serve(input int idx);
    int n;
    n = 0;
    while (!src_r && n < 50) begin step(); n++; end
    check("serve_src_r", 64'(src_r), 64'(1));
    check("serve_grant", 64'(grant), 64'(idx));
    src_a = 1'b1;
    src_d = 18'h2A5A5;
    step();
    src_a = 1'b0;
    n = 0;
    while (req_a == 2'b00 && n < 50) begin step(); n++; end
    check("serve_req_a", 64'(req_a), 64'(2'b01 << idx));
    req_r[idx] = 1'b0;
    step();
  endtask

  initial begin
    int   n;
    int   n_gr;
    int   overlap;
    int   multi;
    logic gseq [4];
    logic prev_busy;

    rst   = 1'b1;
    req_r = 2'b00;
    src_a = 1'b0;
    src_d = '0;

    //          rst   req_r  src_a src_d      req_a  req_d     src_r grant busy  err
    tbl[0]  = '{1'b1, 2'b00, 1'b0, 18'h0,     2'b00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 2'b01, 1'b0, 18'h0,     2'b00, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 2'b01, 1'b0, 18'h0,     2'b00, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 2'b01, 1'b1, 18'h2A5A5, 2'b00, 16'h52D2, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 2'b01, 1'b1, 18'h2A5A5, 2'b00, 16'h52D2, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 2'b01, 1'b0, 18'h0,     2'b01, 16'h52D2, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 2'b01, 1'b0, 18'h0,     2'b01, 16'h52D2, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 2'b00, 1'b0, 18'h0,     2'b00, 16'h52D2, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 2'b10, 1'b0, 18'h0,     2'b00, 16'h52D2, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 2'b11, 1'b1, 18'h2A5A5, 2'b00, 16'hA969, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 2'b11, 1'b0, 18'h0,     2'b10, 16'hA969, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 2'b01, 1'b0, 18'h0,     2'b00, 16'hA969, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 2'b01, 1'b0, 18'h0,     2'b00, 16'hA969, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 2'b01, 1'b0, 18'h0,     2'b00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 14; i++) begin
      rst   = tbl[i].rst;
      req_r = tbl[i].req_r;
      src_a = tbl[i].src_a;
      src_d = tbl[i].src_d;
      step();
      check($sformatf("vec%0d", i),
            64'({req_a, req_d, src_r, grant, busy, err}),
            64'({tbl[i].req_a, tbl[i].req_d, tbl[i].src_r, tbl[i].grant, tbl[i].busy, tbl[i].err}));
    end

    // Both requesters pull continuously; grants must alternate.
    do_reset();
    req_r     = 2'b11;
    src_d     = 18'h2A5A5;
    n_gr      = 0;
    overlap   = 0;
    multi     = 0;
    prev_busy = 1'b0;
    for (int c = 0; c < 200 && n_gr < 4; c++) begin
      step();
      if (busy && !prev_busy) begin
        gseq[n_gr] = grant;
        n_gr++;
      end
      prev_busy = busy;
      if (src_r && req_a != 2'b00) overlap++;
      if (req_a == 2'b11) multi++;
      if (req_a == 2'b01) check("alt_req_d0", 64'(req_d), 64'(16'h52D2));
      if (req_a == 2'b10) check("alt_req_d1", 64'(req_d), 64'(16'hA969));
      src_a = src_r;
      for (int r = 0; r < 2; r++) req_r[r] = !req_a[r];
    end
    check("alt_count", 64'(n_gr), 64'(4));
    for (int g = 0; g < 4; g++) check($sformatf("alt_grant%0d", g), 64'(gseq[g]), 64'(g % 2));
    check("alt_overlap", 64'(overlap), 64'(0));
    check("alt_onehot", 64'(multi), 64'(0));

    // Source never acknowledges: abort after TIMEOUT+1 cycles, then retry.
    do_reset();
    req_r = 2'b01;
    n = 0;
    while (!src_r && n < 10) begin step(); n++; end
    check("to_src_r", 64'(src_r), 64'(1));
    n = 0;
    while (!err && n < 400) begin step(); n++; end
    check("to_cycles", 64'(n), 64'(256));
    check("to_err_outs", 64'({src_r, busy, req_a}), 64'({1'b0, 1'b1, 2'b00}));
    step();
    check("to_err_pulse", 64'({err, busy}), 64'({1'b0, 1'b1}));
    step();
    check("to_idle", 64'({busy, src_r}), 64'(0));
    step();
    check("to_retry", 64'({src_r, grant, busy}), 64'({1'b1, 1'b0, 1'b1}));
    serve(0);

    // Reset during ACK clears everything; rr_ptr restarts at 0.
    do_reset();
    req_r = 2'b01;
    serve(0);
    req_r = 2'b11;
    n = 0;
    while (!src_r && n < 10) begin step(); n++; end
    check("rst_grant1", 64'({src_r, grant}), 64'({1'b1, 1'b1}));
    src_a = 1'b1;
    src_d = 18'h2A5A5;
    step();
    src_a = 1'b0;
    n = 0;
    while (req_a == 2'b00 && n < 10) begin step(); n++; end
    check("rst_in_ack", 64'(req_a), 64'(2'b10));
    rst = 1'b1;
    step();
    check("rst_outs", 64'({req_a, req_d, src_r, grant, busy, err}), 64'(0));
    rst = 1'b0;
    step();
    check("rst_reserve", 64'({src_r, grant, busy}), 64'({1'b1, 1'b0, 1'b1}));
    serve(0);
    serve(1);

    // src_a stuck high in IDLE blocks the request until it drops.
    do_reset();
    src_a = 1'b1;
    req_r = 2'b01;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("stuck_hold%0d", c), 64'({src_r, busy}), 64'(0));
    end
    src_a = 1'b0;
    step();
    check("stuck_release", 64'({src_r, grant, busy}), 64'({1'b1, 1'b0, 1'b1}));
    serve(0);
    check("stuck_done", 64'({busy, err, req_a}), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
